// File: rtl/block_nest_checker.sv
// Streaming "begin"/"end" nesting checker: one character per accepted clock,
// tracking committed depth, peak depth, a sticky error and a balanced flag.
module block_nest_checker #(
   parameter int DEPTH_W  = 8,
   parameter bit CASE_INS = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         in,
   input  logic               in_valid,
   output logic               result,
   output logic [DEPTH_W-1:0] depth,
   output logic [DEPTH_W-1:0] max_depth,
   output logic               error
);

   typedef enum logic [3:0] {
      S_IDLE, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
   } state_t;

   localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

   state_t             state_q, state_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [DEPTH_W-1:0] max_q, max_d;
   logic               err_q, err_d;
   logic [7:0]         ch;
   logic [DEPTH_W-1:0] depth_inc;

   // Only A-Z are folded; every other byte passes through untouched.
   always_comb begin
      ch = in;
      if (CASE_INS && (in >= 8'h41) && (in <= 8'h5A)) begin
         ch = in | 8'h20;
      end
   end

   assign depth_inc = depth_q + DEPTH_ONE;

   always_comb begin
      state_d = state_q;
      depth_d = depth_q;
      max_d   = max_q;
      err_d   = err_q;
      if (in_valid) begin
         if (in == 8'h20) begin
            state_d = S_IDLE;
            case (state_q)
               S_BEGIN: begin
                  if (depth_q == DEPTH_MAX) begin
                     err_d = 1'b1;
                  end else begin
                     depth_d = depth_inc;
                     if (depth_inc > max_q) begin
                        max_d = depth_inc;
                     end
                  end
               end
               S_END: begin
                  if (depth_q == '0) begin
                     err_d = 1'b1;
                  end else begin
                     depth_d = depth_q - DEPTH_ONE;
                  end
               end
               default: ;
            endcase
         end else begin
            state_d = S_OTHER;
            case (state_q)
               S_IDLE: begin
                  if (ch == "b") begin
                     state_d = S_B;
                  end else if (ch == "e") begin
                     state_d = S_E;
                  end
               end
               S_B:    if (ch == "e") state_d = S_BE;
               S_BE:   if (ch == "g") state_d = S_BEG;
               S_BEG:  if (ch == "i") state_d = S_BEGI;
               S_BEGI: if (ch == "n") state_d = S_BEGIN;
               S_E:    if (ch == "n") state_d = S_EN;
               S_EN:   if (ch == "d") state_d = S_END;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         depth_q <= '0;
         max_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
         max_q   <= max_d;
         err_q   <= err_d;
      end
   end

   // A pending keyword is judged as if the word were terminated right now.
   always_comb begin
      if (err_q) begin
         result = 1'b0;
      end else if (state_q == S_BEGIN) begin
         result = 1'b0;
      end else if (state_q == S_END) begin
         result = (depth_q == DEPTH_ONE);
      end else begin
         result = (depth_q == '0);
      end
   end

   assign depth     = depth_q;
   assign max_depth = max_q;
   assign error     = err_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// Three checker configurations driven in parallel and compared every cycle
// against a word-level model, plus literal checkpoints.
module tb_block_nest_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in = 8'h48;
   logic       in_valid = 1'b0;

   logic       res0, res1, res2, err0, err1, err2;
   logic [7:0] dep0, dep1, max0, max1;
   logic [1:0] dep2, max2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   block_nest_checker #(.DEPTH_W(8), .CASE_INS(1'b1)) u0 (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .result(res0), .depth(dep0), .max_depth(max0), .error(err0));
   block_nest_checker #(.DEPTH_W(8), .CASE_INS(1'b0)) u1 (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .result(res1), .depth(dep1), .max_depth(max1), .error(err1));
   block_nest_checker #(.DEPTH_W(2), .CASE_INS(1'b1)) u2 (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .result(res2), .depth(dep2), .max_depth(max2), .error(err2));

   // Word-level model: keep the pending word as text, judge it on space.
   string m_word [3];
   int    m_depth[3];
   int    m_max  [3];
   bit    m_err  [3];
   int    m_case [3] = '{1, 0, 1};
   int    m_lim  [3] = '{255, 255, 3};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_result(input int k);
      if (m_err[k]) return 0;
      if (m_word[k] == "begin") return 0;
      if (m_word[k] == "end") return (m_depth[k] == 1) ? 1 : 0;
      return (m_depth[k] == 0) ? 1 : 0;
   endfunction

   task automatic model_step(input int k, input logic [7:0] c);
      logic [7:0] fc;
      if (c == 8'h20) begin
         if (m_word[k] == "begin") begin
            if (m_depth[k] == m_lim[k]) m_err[k] = 1'b1;
            else begin
               m_depth[k]++;
               if (m_depth[k] > m_max[k]) m_max[k] = m_depth[k];
            end
         end else if (m_word[k] == "end") begin
            if (m_depth[k] == 0) m_err[k] = 1'b1;
            else m_depth[k]--;
         end
         m_word[k] = "";
      end else begin
         fc = c;
         if (m_case[k] != 0 && c >= "A" && c <= "Z") fc = c + 8'd32;
         if (m_word[k].len() < 8) m_word[k] = $sformatf("%s%c", m_word[k], fc);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < 3; k++) begin
            m_word[k] = ""; m_depth[k] = 0; m_max[k] = 0; m_err[k] = 1'b0;
         end
      end else if (in_valid) begin
         for (int k = 0; k < 3; k++) model_step(k, in);
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("u0.result", int'(res0), model_result(0));
         chk("u0.depth", int'(dep0), m_depth[0]);
         chk("u0.max_depth", int'(max0), m_max[0]);
         chk("u0.error", int'(err0), int'(m_err[0]));
         chk("u1.result", int'(res1), model_result(1));
         chk("u1.depth", int'(dep1), m_depth[1]);
         chk("u1.max_depth", int'(max1), m_max[1]);
         chk("u1.error", int'(err1), int'(m_err[1]));
         chk("u2.result", int'(res2), model_result(2));
         chk("u2.depth", int'(dep2), m_depth[2]);
         chk("u2.max_depth", int'(max2), m_max[2]);
         chk("u2.error", int'(err2), int'(m_err[2]));
      end
   end

   task automatic send(input logic [7:0] c, input logic v);
      in = c;
      in_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i], 1'b1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, " u0.result"}, int'(res0), 1);
      chk({tag, " u0.depth"}, int'(dep0), 0);
      chk({tag, " u0.max_depth"}, int'(max0), 0);
      chk({tag, " u0.error"}, int'(err0), 0);
      chk({tag, " u2.depth"}, int'(dep2), 0);
      chk({tag, " u1.result"}, int'(res1), 1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in = "H";
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("in_reset");
      reset = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      // Mixed-case prose with one open block and a pending "End".
      do_reset();
      send_str("Hello world begi");
      chk("t1 before n result", int'(res0), 1);
      send_str("n");
      chk("t1 after n result", int'(res0), 0);
      send_str(" ");
      chk("t1 commit depth", int'(dep0), 1);
      send_str("comPuTer orGANization End");
      chk("t1 result", int'(res0), 1);
      chk("t1 depth", int'(dep0), 1);
      chk("t1 max_depth", int'(max0), 1);
      chk("t1 error", int'(err0), 0);
      chk("t1 case-sensitive result", int'(res1), 0);

      do_reset();
      send_str("BEGIN end ");
      chk("t2 cs depth", int'(dep1), 0);
      chk("t2 cs error", int'(err1), 1);
      chk("t2 cs result", int'(res1), 0);
      chk("t2 ci error", int'(err0), 0);
      chk("t2 ci result", int'(res0), 1);

      do_reset();
      send_str("end ");
      chk("t3 early error", int'(err0), 1);
      send_str("begin end ");
      chk("t3 error sticky", int'(err0), 1);
      chk("t3 depth", int'(dep0), 0);
      chk("t3 result", int'(res0), 0);

      do_reset();
      send_str("beginx endd begin begin end ");
      chk("t4 max_depth", int'(max0), 2);
      chk("t4 depth", int'(dep0), 1);
      chk("t4 result", int'(res0), 0);
      chk("t4 error", int'(err0), 0);

      do_reset();
      for (int i = 0; i < 7; i++) begin
         send_str("begin ");
         if (i == 2) chk("t5 depth at 3rd", int'(dep2), 3);
         if (i == 2) chk("t5 no error yet", int'(err2), 0);
         if (i == 3) chk("t5 overflow error", int'(err2), 1);
      end
      chk("t5 depth", int'(dep2), 3);
      chk("t5 max_depth", int'(max2), 3);
      chk("t5 wide depth", int'(dep0), 7);

      do_reset();
      send_str("beg");
      repeat (3) send("#", 1'b0);
      send_str("in end");
      chk("t6 result", int'(res0), 1);
      chk("t6 depth", int'(dep0), 1);
      send_str(" begin begin ");
      chk("t6 depth 2", int'(dep0), 2);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals("async");
      @(posedge clk);
      #1;
      reset = 1'b0;
      send_str("x ");
      chk("t6 after reset depth", int'(dep0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
